// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the autoplay song sequencer: FSM encoding, note codes
// and the layout of a song ROM entry.
package song_sequencer_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StLatch,
      StPlay,
      StGap,
      StPause,
      StDone
   } seq_state_e;

   localparam logic [4:0] NOTE_REST  = 5'd0;
   localparam logic [4:0] NOTE_MAX   = 5'd21;
   localparam logic [7:0] END_MARKER = 8'h00;

   // ROM entry layout: {note[7:3], dur[2:0]}
   function automatic logic [4:0] entry_note(input logic [7:0] entry);
      return entry[7:3];
   endfunction

   function automatic logic [2:0] entry_dur(input logic [7:0] entry);
      return entry[2:0];
   endfunction

endpackage

// File: rtl/song_sequencer_beat_tick_gen.sv
// Beat prescaler: counts clock cycles while enabled and emits a one-cycle tick
// every period. The period is latched from tempo_sel on load so a tempo change
// only affects the next note.
module song_sequencer_beat_tick_gen #(
   parameter int unsigned TICK_CYCLES = 6_250_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en_i,
   input  logic       clr_i,
   input  logic       freeze_i,
   input  logic       load_i,
   input  logic [1:0] tempo_sel_i,
   output logic       tick_o
);

   localparam int unsigned CW = $clog2(TICK_CYCLES + 1);
   localparam logic [CW-1:0] One = CW'(1);

   logic [CW-1:0] period_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] period_sel;

   // Selected period; a shift that underflows to 0 is held at one cycle per tick
   always_comb begin
      period_sel = CW'(TICK_CYCLES >> tempo_sel_i);
      if (period_sel == '0) begin
         period_sel = One;
      end
   end

   assign tick_o = en_i && !freeze_i && (cnt_q == period_q - One);

   // Period latch and cycle counter; freeze holds the count across a pause
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (load_i) begin
            period_q <= period_sel;
         end
         if (clr_i) begin
            cnt_q <= '0;
         end else if (freeze_i) begin
            cnt_q <= cnt_q;
         end else if (en_i) begin
            cnt_q <= tick_o ? '0 : cnt_q + One;
         end
      end
   end

endmodule

// File: rtl/song_sequencer.sv
// Autoplay controller: walks the song ROM, holds each note for its programmed
// number of beat ticks, inserts an articulation gap, and handles start, pause,
// stop and looping.
module song_sequencer #(
   parameter int unsigned TICK_CYCLES = 6_250_000,
   parameter int unsigned GAP_TICKS   = 1,
   parameter int unsigned SONG_DEPTH  = 64,
   parameter int unsigned AW          = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_i,
   input  logic          pause_i,
   input  logic          stop_i,
   input  logic          loop_en_i,
   input  logic [1:0]    tempo_sel_i,
   output logic [AW-1:0] rom_addr_o,
   input  logic [7:0]    rom_data_i,
   output logic [4:0]    note_o,
   output logic          busy_o,
   output logic          paused_o,
   output logic          done_o
);

   import song_sequencer_pkg::*;

   localparam logic [AW-1:0] LastAddr = AW'(SONG_DEPTH - 1);
   localparam logic [7:0]    GapLen   = 8'(GAP_TICKS);

   seq_state_e    state_q;
   seq_state_e    ret_q;
   logic [AW-1:0] rom_addr_q;
   logic [4:0]    note_q;
   logic [4:0]    cur_note_q;
   logic [7:0]    tick_cnt_q;
   logic [7:0]    target_q;
   logic          busy_q;
   logic          paused_q;
   logic          done_q;

   logic          tick;
   logic [7:0]    tick_cnt_inc;
   logic          play_last;
   logic          gap_last;
   logic          is_end;

   assign tick_cnt_inc = tick_cnt_q + 8'd1;
   assign play_last    = tick && (tick_cnt_inc == target_q);
   assign gap_last     = tick && (tick_cnt_inc == GapLen);
   assign is_end       = (rom_data_i == END_MARKER);

   song_sequencer_beat_tick_gen #(
      .TICK_CYCLES (TICK_CYCLES)
   ) u_tick_gen (
      .clk         (clk),
      .rst         (rst),
      .en_i        ((state_q == StPlay) || (state_q == StGap)),
      .clr_i       (stop_i || (state_q == StLatch)),
      .freeze_i    (state_q == StPause),
      .load_i      (state_q == StLatch),
      .tempo_sel_i (tempo_sel_i),
      .tick_o      (tick)
   );

   // Sequencer FSM with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         ret_q      <= StIdle;
         rom_addr_q <= '0;
         note_q     <= NOTE_REST;
         cur_note_q <= NOTE_REST;
         tick_cnt_q <= '0;
         target_q   <= '0;
         busy_q     <= 1'b0;
         paused_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (stop_i) begin
            state_q    <= StIdle;
            ret_q      <= StIdle;
            rom_addr_q <= '0;
            note_q     <= NOTE_REST;
            tick_cnt_q <= '0;
            target_q   <= '0;
            busy_q     <= 1'b0;
            paused_q   <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle, StDone: begin
                  if (start_i) begin
                     state_q    <= StFetch;
                     rom_addr_q <= '0;
                     busy_q     <= 1'b1;
                  end
               end
               StFetch: begin
                  state_q <= StLatch;
               end
               StLatch: begin
                  if (is_end) begin
                     if (loop_en_i) begin
                        rom_addr_q <= '0;
                        state_q    <= StFetch;
                     end else begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end
                  end else begin
                     note_q     <= entry_note(rom_data_i);
                     cur_note_q <= entry_note(rom_data_i);
                     tick_cnt_q <= '0;
                     target_q   <= 8'(entry_dur(rom_data_i)) + 8'd1;
                     state_q    <= StPlay;
                  end
               end
               StPlay: begin
                  if (tick) begin
                     tick_cnt_q <= play_last ? '0 : tick_cnt_inc;
                  end
                  if (pause_i) begin
                     // A tick landing on the pause edge still counts toward the note
                     state_q  <= StPause;
                     ret_q    <= play_last ? StGap : StPlay;
                     note_q   <= NOTE_REST;
                     paused_q <= 1'b1;
                  end else if (play_last) begin
                     note_q  <= NOTE_REST;
                     state_q <= StGap;
                  end
               end
               StGap: begin
                  if (gap_last) begin
                     // Gap completion wins over a coincident pause
                     tick_cnt_q <= '0;
                     if (rom_addr_q == LastAddr) begin
                        if (loop_en_i) begin
                           rom_addr_q <= '0;
                           state_q    <= StFetch;
                        end else begin
                           state_q <= StDone;
                           busy_q  <= 1'b0;
                           done_q  <= 1'b1;
                        end
                     end else begin
                        rom_addr_q <= rom_addr_q + 1'b1;
                        state_q    <= StFetch;
                     end
                  end else begin
                     if (tick) begin
                        tick_cnt_q <= tick_cnt_inc;
                     end
                     if (pause_i) begin
                        state_q  <= StPause;
                        ret_q    <= StGap;
                        paused_q <= 1'b1;
                     end
                  end
               end
               StPause: begin
                  if (start_i) begin
                     state_q  <= ret_q;
                     paused_q <= 1'b0;
                     if (ret_q == StPlay) begin
                        note_q <= cur_note_q;
                     end
                  end
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   assign rom_addr_o = rom_addr_q;
   assign note_o     = note_q;
   assign busy_o     = busy_q;
   assign paused_o   = paused_q;
   assign done_o     = done_q;

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Autoplay controller for the piano: steps through an external song ROM and presents one 5-bit note code at a time (0 = rest, 1–21 = three octaves × 7 notes) to the key-LED decoder and the tone generator.
- Each note is held for a programmed number of beat ticks, followed by a short articulation gap.
- Supports start, pause, stop, loop and four tempo settings.
- Sits between the mode/button logic and the note-to-key/tone datapath; in autoplay mode it is the sole driver of the note code.

Parameters:
- TICK_CYCLES, 6_250_000: clock cycles per beat tick at tempo_sel=0 (1/16 s at 100 MHz).
- GAP_TICKS, 1: silent ticks inserted after every note. Must be ≥ 1.
- SONG_DEPTH, 64: number of ROM entries. Must be a power of two.
- AW, 6: ROM address width, equal to log2(SONG_DEPTH).

Ports:
- clk, in, 1: system clock, 100 MHz.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: one-cycle pulse. Begins playback from IDLE or DONE; resumes from PAUSE.
- pause, in, 1: one-cycle pulse. Pauses while in PLAY or GAP.
- stop, in, 1: one-cycle pulse. Abort and return to IDLE from any state.
- loop_en, in, 1: level. When 1, restart at address 0 on end-of-song instead of finishing.
- tempo_sel, in, 2: tick period = TICK_CYCLES >> tempo_sel (x1, x2, x4, x8 speed).
- rom_addr, out, AW: song ROM address.
- rom_data, in, 8: {note[7:3], dur[2:0]}, synchronous ROM, valid the cycle after rom_addr.
- note, out, 5: current note code; 0 whenever not sounding.
- busy, out, 1: high in every state except IDLE and DONE.
- paused, out, 1: high in PAUSE.
- done, out, 1: one-cycle pulse on a non-looping end-of-song.

Behaviour:
- Reset values: all outputs 0 (rom_addr=0, note=0, busy=0, paused=0, done=0); state IDLE; all counters 0.
- FSM states: IDLE, FETCH, LATCH, PLAY, GAP, PAUSE, DONE.
- IDLE/DONE, start → FETCH with rom_addr=0.
- FETCH → LATCH unconditionally. rom_addr is stable during FETCH.
- LATCH: capture rom_data.
  - Entry 8'h00 is the end marker.
    - With loop_en=1: rom_addr←0 and go to FETCH.
    - With loop_en=0: go to DONE and pulse done.
  - Otherwise: note←rom_data[7:3], tick_cnt←0, target←dur+1 ticks, go to PLAY.
  - A note field of 0 with nonzero dur is a timed rest.
  - A note field of 22–31 is passed through unchanged; range checking belongs to the downstream decoder.
- Latency: start sampled at edge k → note valid after edge k+2.
- PLAY: count ticks. When tick_cnt reaches target, note←0, tick_cnt←0, go to GAP.
- GAP: after GAP_TICKS ticks, advance the address.
  - If rom_addr = SONG_DEPTH-1, treat it as end-of-song (same loop/done rule as the end marker), with no FETCH of a wrapped address.
  - Otherwise rom_addr←rom_addr+1, go to FETCH.
- Tick generator:
  - Cycle counter runs only in PLAY and GAP. Tick = counter reaching period-1; counter then clears.
  - The period is sampled when a note is latched, so a tempo change takes effect on the next note.
- pause in PLAY or GAP → PAUSE.
  - Save the return state, the cycle counter and tick_cnt; note←0; paused=1.
  - pause while in PAUSE has no effect.
- start in PAUSE → return to the saved state with the saved counters and the note restored (PLAY) or kept at 0 (GAP).
- start while in FETCH, LATCH, PLAY or GAP is ignored.
- Same-cycle priority: stop > start > pause.
- stop from any state → IDLE next edge: note=0, rom_addr=0, counters cleared, done not pulsed.
- done is high for exactly the one cycle on which DONE is entered. DONE holds note=0.
- rst asserted mid-song → immediate return to reset values regardless of clk.

Decomposition:
- Shared piano package holds:
  - FSM state encoding.
  - NOTE_REST=5'd0 and NOTE_MAX=5'd21.
  - ROM entry field slices (note = [7:3], dur = [2:0]) and END_MARKER=8'h00.
- One sub-module, beat_tick_gen: prescaler with enable, clear, freeze and a tempo_sel-derived period; emits a one-cycle tick.

Test Plan (TICK_CYCLES=4, GAP_TICKS=1, SONG_DEPTH=8):
- ROM {8'h41 (note 8, dur 1), 8'h00}, start pulse → note=8 from k+2 for 8 cycles, then note=0 for 4 cycles, then done pulses once; busy falls with done.
- Same ROM, pause issued 3 cycles into the note, start 10 cycles later → note=0 and paused=1 during the hold; after resume note=8 for the remaining 5 cycles; total sounding time still 8 cycles.
- ROM {8'hA8 (note 21, dur 0), 8'h00}, loop_en=1 → rom_addr sequence 0,1,0,1…; note=21 for 4 cycles per pass; done never asserted.
- tempo_sel=2 (period 1 cycle), 8 nonzero entries with no end marker → each note lasts dur+1 cycles; after address 7 the block enters DONE with rom_addr never wrapping.
- stop and start asserted in the same cycle mid-note → IDLE next edge, note=0, rom_addr=0, done=0.
- rst pulse during GAP → all outputs 0 asynchronously; a subsequent start replays from address 0.
